dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data SRAM responder for the MEM stage; holds the pipeline on stall_o while an access is in flight.
// Define DMEM_PERF_CNT_EN to add the stall_cnt_o / access_cnt_o performance counters.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] WrData_i,
  output logic [31:0] RdData_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        conflict_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] access_cnt_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               op_rd_q, op_wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               req;
  logic               aligned;
  logic               accept;
  logic               enter_done;
  logic               commit_rd, commit_wr;
  logic [IDX_W-1:0]   commit_idx;
  logic [31:0]        commit_data;
  logic               unused_addr;

  assign req         = MemRd_i | MemWr_i;
  assign aligned     = (addr_i[1:0] == 2'b00);
  assign unused_addr = ^addr_i[31:IDX_W+2];

  // FSM: next state, counter and the combinational handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    conflict_o = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            accept     = 1'b1;
            stall_o    = 1'b1;
            conflict_o = MemRd_i & MemWr_i;
            if (LATENCY == 1) begin
              state_d = DONE;
              cnt_d   = 4'd0;
            end else begin
              state_d = BUSY;
              cnt_d   = 4'(LATENCY - 1);
            end
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With LATENCY=1 the commit happens on the accept edge, so the live inputs are used instead of the latches
  always_comb begin
    enter_done  = (state_d == DONE) && (state_q != DONE);
    commit_rd   = accept ? MemRd_i : op_rd_q;
    commit_wr   = accept ? MemWr_i : op_wr_q;
    commit_idx  = accept ? addr_i[IDX_W+1:2] : idx_q;
    commit_data = accept ? WrData_i : wdata_q;
  end

  // Control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_rd_q <= MemRd_i;
        op_wr_q <= MemWr_i;
      end
      if (enter_done && commit_rd && !commit_wr) begin
        rdata_q <= mem_q[commit_idx];
      end
    end
  end

  // Latched request payload and storage; neither is cleared by reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= addr_i[IDX_W+1:2];
      wdata_q <= WrData_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_done && commit_wr) begin
      mem_q[commit_idx] <= commit_data;
    end
  end

  assign RdData_o = rdata_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] access_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= 32'd0;
      access_cnt_q <= 32'd0;
    end else begin
      if (stall_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (state_q == DONE) begin
        access_cnt_q <= access_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign access_cnt_o = access_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver behaves like the frozen pipeline, a monitor checks every completed access.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRd_i, MemWr_i;
  logic [31:0] addr_i, WrData_i;
  logic [31:0] RdData_o;
  logic        stall_o, misalign_o, conflict_o;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] stall_cnt_o, access_cnt_o;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRd_i    (MemRd_i),
    .MemWr_i    (MemWr_i),
    .addr_i     (addr_i),
    .WrData_i   (WrData_i),
    .RdData_o   (RdData_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .conflict_o (conflict_o)
`ifdef DMEM_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .access_cnt_o (access_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          mis;
    int          stalls;
    bit          cf;
    bit          known;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [int];
  logic [31:0] rd_model;
  bit          rd_known;
  int          st_tot, ac_tot;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts each stall run and scores it when stall_o drops, or scores a misaligned reject
  int   run = 0;
  logic cf_seen = 1'b0;
  exp_t me;
  always @(negedge clk_i) begin
    if (rst_i) begin
      run = 0;
    end else if (stall_o) begin
      if (run == 0) cf_seen = conflict_o;
      run++;
    end else if (run > 0 || misalign_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_response: stall_run=%0d misalign=%0b with empty scoreboard", run, misalign_o);
      end else begin
        me = exp_q.pop_front();
        check("misalign_flag", {31'b0, misalign_o}, {31'b0, me.mis});
        check("stall_cycles", 32'(run), 32'(me.stalls));
        if (!me.mis) check("conflict_flag", {31'b0, cf_seen}, {31'b0, me.cf});
        if (me.known) check("rd_data", RdData_o, me.rd);
      end
      run = 0;
    end
  end

  // Reference model of one access, then present it and hold it until the pipeline would advance
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    bit   got;
    idx = int'((addr >> 2) % DEPTH);
    e.mis = (addr % 4) != 0;
    e.stalls = 0;
    e.cf = 1'b0;
    if (!e.mis) begin
      e.stalls = LAT;
      e.cf = rd && wr;
      if (wr) begin
        mem_m[idx] = data;
      end else if (mem_m.exists(idx)) begin
        rd_model = mem_m[idx];
        rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
      st_tot += LAT;
      ac_tot += 1;
    end
    e.rd = rd_model;
    e.known = rd_known;
    exp_q.push_back(e);
    MemRd_i = rd; MemWr_i = wr; addr_i = addr; WrData_i = data;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL access_timeout: stall_o still %0b after 64 cycles, required 0", stall_o);
    end
    @(posedge clk_i); #1;
    MemRd_i = 1'b0; MemWr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    MemRd_i = 1'b0; MemWr_i = 1'b0;
    exp_q.delete();
    rd_model = 32'd0; rd_known = 1'b1;
    st_tot = 0; ac_tot = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    MemRd_i = 1'b0; MemWr_i = 1'b0; addr_i = 32'd0; WrData_i = 32'd0;
    rd_model = 32'd0; rd_known = 1'b1; st_tot = 0; ac_tot = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_rddata", RdData_o, 32'd0);
    check("reset_misalign", {31'b0, misalign_o}, 32'd0);
    check("reset_conflict", {31'b0, conflict_o}, 32'd0);
    @(posedge clk_i); #1;

    // Directed: write/read, misaligned reject, read-back
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    do_access(1'b1, 1'b0, 32'h13, 32'h0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);

    // Reset in the second BUSY cycle aborts the write
    do_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
    MemWr_i = 1'b1; addr_i = 32'h20; WrData_i = 32'h12345678;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b1; MemWr_i = 1'b0;
    exp_q.delete();
    rd_model = 32'd0; rd_known = 1'b1; st_tot = 0; ac_tot = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midop_reset_stall", {31'b0, stall_o}, 32'd0);
    check("midop_reset_rddata", RdData_o, 32'd0);
    @(posedge clk_i); #1;
    do_access(1'b1, 1'b0, 32'h20, 32'h0);

    // Address wrap
    do_access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    do_access(1'b1, 1'b0, 32'h000, 32'h0);

    // Read+write conflict after a clean reset
    do_reset();
    do_access(1'b1, 1'b1, 32'h8, 32'h1);
`ifdef DMEM_PERF_CNT_EN
    check("perf_access_cnt", access_cnt_o, 32'(ac_tot));
    check("perf_stall_cnt", stall_cnt_o, 32'(st_tot));
`endif
    do_access(1'b1, 1'b0, 32'h8, 32'h0);

    // Randomized traffic over 16 words, with aliases, misalignment and idle gaps
    for (int w = 0; w < 16; w++) do_access(1'b0, 1'b1, 32'(w) << 2, $urandom);
    for (int n = 0; n < 150; n++) begin
      int unsigned w, a, mis, op;
      logic [31:0] addr;
      w   = $urandom_range(0, 15);
      a   = $urandom_range(0, 3);
      mis = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      op  = $urandom_range(0, 4);
      addr = (32'(a) << 10) | (32'(w) << 2) | 32'(mis);
      do_access(op <= 1 || op == 4, op >= 2, addr, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
      end
    end
`ifdef DMEM_PERF_CNT_EN
    check("perf_access_cnt_end", access_cnt_o, 32'(ac_tot));
    check("perf_stall_cnt_end", stall_cnt_o, 32'(st_tot));
`endif

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
